muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit holding the HI/LO result pair.

---
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit holding the HI/LO result pair
//
// Computes one bit per cycle. Multiply uses shift-add and divide uses
// restoring division. Signed operations work on operand magnitudes, and the
// FIX state applies the sign correction. HI/LO can also be loaded directly
// with MTHI/MTLO while the unit is idle.
//
// Ports:
//   clk    - clock, all state changes on posedge
//   rst_n  - synchronous active-low reset
//   start  - operation request, sampled only in IDLE
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busA   - multiplicand / dividend, latched at start
//   busB   - multiplier / divisor, latched at start
//   mthi   - write wdata to HI (idle only, start=0)
//   mtlo   - write wdata to LO (idle only, start=0)
//   wdata  - data for mthi/mtlo
//   busy   - high while in RUN or FIX
//   done   - one-cycle pulse when new HI/LO become visible
//   hi     - HI register (product upper half / remainder)
//   lo     - LO register (product lower half / quotient)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;   // latched op[1]
  logic               neg_a;    // dividend/multiplicand was negative (signed ops only)
  logic               neg_b;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;    // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   opnd;     // multiplicand magnitude (mul) or divisor magnitude (div)
  // Shared accumulator. Mul: running product with the multiplier shifting out
  // of the low end. Div: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;

  logic               start_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shl;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  always_comb begin
    start_signed = ~op[0];
    a_mag = (start_signed && busA[WIDTH-1]) ? -busA : busA;
    b_mag = (start_signed && busB[WIDTH-1]) ? -busB : busB;

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Restoring step: shift the next dividend bit into the remainder and
    // subtract if the divisor fits. A remainder below the divisor fits in WIDTH+1 bits.
    div_shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_shl - {1'b0, opnd};

    acc_next = acc;
    if (!is_div) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {div_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    prod_fixed = (neg_a ^ neg_b) ? -acc : acc;
    quo_fixed  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div   <= op[1];
            neg_a    <= start_signed & busA[WIDTH-1];
            neg_b    <= start_signed & busB[WIDTH-1];
            div_zero <= op[1] && (busB == '0);
            a_raw    <= busA;
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busA(busA), .busB(busB),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0; returns in cycle 34 after checking done/result.
  // inj: RUN cycle in which a stray start (new operands) plus mthi/mtlo is driven.
  // mt0: drive mtlo together with start in cycle 0.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int inj, input bit mt0);
    start = 1'b1; op = o; busA = a; busB = b;
    mtlo = mt0; wdata = 32'h0BAD0BAD;
    step();
    for (int c = 1; c <= 33; c++) begin
      busA = 32'h5A5A5A5A; busB = 32'h00000001; op = ~o;
      if (c == inj) begin
        start = 1'b1; busA = 32'h11111111; busB = 32'h00000003;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      check({tag, " done"}, {31'b0, done}, 32'd0);
      check({tag, " hi hold"}, hi, m_hi);
      check({tag, " lo hold"}, lo, m_lo);
      step();
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    check({tag, " done34"}, {31'b0, done}, 32'd1);
    check({tag, " busy34"}, {31'b0, busy}, 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    #2;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    step();
    step();
    @(negedge clk);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    #2;
    rst_n = 1'b1;

    run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1'b0);
    step();
    @(negedge clk);
    check("mult done35", {31'b0, done}, 32'd0);
    check("mult hi35", hi, 32'hFFFFFFFF);
    #2;

    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b0);
    run_op("b2b divu", OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 0, 1'b0);
    run_op("div neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
    run_op("divu zero", OP_DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 1'b0);
    run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b0);
    run_op("div zero s", OP_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0, 1'b0);
    run_op("stray start", OP_MULT, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 5, 1'b0);

    // Reset in cycle 10 of a new operation.
    start = 1'b1; op = OP_MULTU; busA = 32'd3; busB = 32'd3;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rst mid busy", {31'b0, busy}, 32'd0);
    check("rst mid hi", hi, 32'h0);
    check("rst mid lo", lo, 32'h0);
    check("rst mid done", {31'b0, done}, 32'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("rst no done", {31'b0, done}, 32'd0);
      #2;
    end

    // Move-to-HI in IDLE.
    mthi = 1'b1; wdata = 32'hDEADBEEF;
    step();
    mthi = 1'b0; wdata = 32'h0;
    @(negedge clk);
    check("mthi hi", hi, 32'hDEADBEEF);
    check("mthi lo", lo, 32'h0);
    m_hi = 32'hDEADBEEF;
    #2;

    // mtlo with start, then mtlo/mthi during RUN: both ignored.
    run_op("mt ignored", OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 5, 1'b1);

    // Both moves together in IDLE.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h01234567;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    check("mt both hi", hi, 32'h01234567);
    check("mt both lo", lo, 32'h01234567);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
